// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue.
//  - addOp field positions and size encodings
//  - MEMOP_* encodings driven on memOp ({store, size})
//  - head state type and the load-result extend function
package lsq_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  localparam logic [2:0] MEMOP_LB = 3'b000;
  localparam logic [2:0] MEMOP_LH = 3'b001;
  localparam logic [2:0] MEMOP_LW = 3'b011;
  localparam logic [2:0] MEMOP_SB = 3'b100;
  localparam logic [2:0] MEMOP_SH = 3'b101;
  localparam logic [2:0] MEMOP_SW = 3'b111;

  typedef enum logic {ST_WAIT, ST_ISSUE} head_state_e;

  // Sign- or zero-extend raw read data according to the load's addOp.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [3:0] op);
    case (op[1:0])
      SZ_B:    extend = op[OP_UNS] ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_H:    extend = op[OP_UNS] ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

endpackage

// File: rtl/lsq_wakeup.sv
// Operand wakeup for one queue operand.
//  i_tag/i_busy/i_val : operand producer tag, tag-valid flag, current value
//  i_chFlag/Tag/Val   : NCH broadcast channels, channel 0 has highest priority
//  o_busy/o_val       : operand state after this cycle's broadcasts
module lsq_wakeup #(
  parameter int TAG_W = 4,
  parameter int NCH   = 3
) (
  input  logic [TAG_W-1:0]           i_tag,
  input  logic                       i_busy,
  input  logic [31:0]                i_val,
  input  logic [NCH-1:0]             i_chFlag,
  input  logic [NCH-1:0][TAG_W-1:0]  i_chTag,
  input  logic [NCH-1:0][31:0]       i_chVal,
  output logic                       o_busy,
  output logic [31:0]                o_val
);

  // Scan from the lowest-priority channel up so channel 0 wins the last write.
  always_comb begin
    o_busy = i_busy;
    o_val  = i_val;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (i_busy && i_chFlag[c] && (i_chTag[c] == i_tag)) begin
        o_busy = 1'b0;
        o_val  = i_chVal[c];
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue. Holds memory ops, wakes operands from NUM_CDB
// broadcast channels plus its own load result, issues one access at a time,
// returns load results. Stores issue only once committed by the ROB and
// survive a misprediction flush.
// Ports: clockIn/resetIn (sync, active-high), readyIn (global stall),
//  clearIn (flush), add* (enqueue), full/count, cdb* (broadcasts),
//  robFlag/robDest/robHead (commit), out* (load result), mem* (memory side).
// Option: LSQ_MMIO_GUARD_EN -- loads with Vj[17:16]==2'b11 wait until their
//  tag reaches the ROB head.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int LSQ_WIDTH = 4,
  parameter int NUM_CDB   = 2
) (
  input  logic                          clockIn,
  input  logic                          resetIn,
  input  logic                          readyIn,
  input  logic                          clearIn,
  input  logic                          addFlag,
  input  logic [3:0]                    addOp,
  input  logic [31:0]                   addVj,
  input  logic [31:0]                   addVk,
  input  logic [ROB_WIDTH-1:0]          addQj,
  input  logic [ROB_WIDTH-1:0]          addQk,
  input  logic                          addQjBusy,
  input  logic                          addQkBusy,
  input  logic [31:0]                   addImm,
  input  logic [ROB_WIDTH-1:0]          addDest,
  output logic                          full,
  output logic [LSQ_WIDTH:0]            count,
  input  logic [NUM_CDB-1:0]            cdbFlag,
  input  logic [32*NUM_CDB-1:0]         cdbVal,
  input  logic [ROB_WIDTH*NUM_CDB-1:0]  cdbDest,
  input  logic                          robFlag,
  input  logic [ROB_WIDTH-1:0]          robDest,
  input  logic [ROB_WIDTH-1:0]          robHead,
  output logic                          outFlag,
  output logic [31:0]                   outVal,
  output logic [ROB_WIDTH-1:0]          outDest,
  output logic                          memOutFlag,
  output logic [2:0]                    memOp,
  output logic [31:0]                   memAddr,
  output logic [31:0]                   memDataOut,
  input  logic [31:0]                   memDataIn,
  input  logic                          memOkFlag
);

  localparam int LSQ_SIZE = 1 << LSQ_WIDTH;
  localparam int NCH      = NUM_CDB + 1;

  typedef logic [ROB_WIDTH-1:0] tag_t;
  typedef logic [LSQ_WIDTH-1:0] idx_t;

  typedef struct packed {
    logic        busy;
    logic        committed;
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    tag_t        qj;
    tag_t        qk;
    logic        qjBusy;
    logic        qkBusy;
    tag_t        dest;
  } ent_t;

  ent_t             r_q [LSQ_SIZE];
  idx_t             r_head, r_tail, r_lastCommit;
  logic [LSQ_WIDTH:0] r_count;
  head_state_e      r_state;
  logic             r_memReg;
  logic [2:0]       r_memOp;
  logic [31:0]      r_memAddr, r_memData;
  logic             r_outFlag;
  logic [31:0]      r_outVal;
  tag_t             r_outDest;

  // Broadcast channels: own load result first, then the external CDBs.
  logic [NCH-1:0]            w_chFlag;
  logic [NCH-1:0][ROB_WIDTH-1:0] w_chTag;
  logic [NCH-1:0][31:0]      w_chVal;

  always_comb begin
    w_chFlag[0] = r_outFlag;
    w_chTag[0]  = r_outDest;
    w_chVal[0]  = r_outVal;
    for (int c = 0; c < NUM_CDB; c++) begin
      w_chFlag[c+1] = cdbFlag[c];
      w_chTag[c+1]  = cdbDest[c*ROB_WIDTH +: ROB_WIDTH];
      w_chVal[c+1]  = cdbVal[c*32 +: 32];
    end
  end

  // Wakeup for every resident operand plus the incoming one.
  logic [LSQ_SIZE-1:0]       w_qjBusy, w_qkBusy;
  logic [LSQ_SIZE-1:0][31:0] w_vj, w_vk;
  logic                      w_enqQjBusy, w_enqQkBusy;
  logic [31:0]               w_enqVj, w_enqVk;

  for (genvar i = 0; i < LSQ_SIZE; i++) begin : g_wake
    lsq_wakeup #(.TAG_W(ROB_WIDTH), .NCH(NCH)) u_j (
      .i_tag(r_q[i].qj), .i_busy(r_q[i].qjBusy), .i_val(r_q[i].vj),
      .i_chFlag(w_chFlag), .i_chTag(w_chTag), .i_chVal(w_chVal),
      .o_busy(w_qjBusy[i]), .o_val(w_vj[i]));
    lsq_wakeup #(.TAG_W(ROB_WIDTH), .NCH(NCH)) u_k (
      .i_tag(r_q[i].qk), .i_busy(r_q[i].qkBusy), .i_val(r_q[i].vk),
      .i_chFlag(w_chFlag), .i_chTag(w_chTag), .i_chVal(w_chVal),
      .o_busy(w_qkBusy[i]), .o_val(w_vk[i]));
  end

  lsq_wakeup #(.TAG_W(ROB_WIDTH), .NCH(NCH)) u_enq_j (
    .i_tag(addQj), .i_busy(addQjBusy), .i_val(addVj),
    .i_chFlag(w_chFlag), .i_chTag(w_chTag), .i_chVal(w_chVal),
    .o_busy(w_enqQjBusy), .o_val(w_enqVj));
  lsq_wakeup #(.TAG_W(ROB_WIDTH), .NCH(NCH)) u_enq_k (
    .i_tag(addQk), .i_busy(addQkBusy), .i_val(addVk),
    .i_chFlag(w_chFlag), .i_chTag(w_chTag), .i_chVal(w_chVal),
    .o_busy(w_enqQkBusy), .o_val(w_enqVk));

  // Head entry issue decision.
  ent_t w_h;
  logic w_isStore, w_commitOk, w_guardOk, w_canIssue, w_done, w_enq;

  assign w_h        = r_q[r_head];
  assign w_isStore  = w_h.op[OP_STORE];
  assign w_commitOk = w_h.committed | (robFlag & (robDest == w_h.dest));
`ifdef LSQ_MMIO_GUARD_EN
  // I/O-space loads must not execute speculatively.
  assign w_guardOk  = (w_h.vj[17:16] != 2'b11) | (w_h.dest == robHead);
`else
  assign w_guardOk  = 1'b1;
`endif
  assign w_canIssue = (r_state == ST_WAIT) & w_h.busy & ~clearIn & ~w_h.qjBusy &
                      (w_isStore ? (~w_h.qkBusy & w_commitOk) : w_guardOk);
  assign w_done     = (r_state == ST_ISSUE) & memOkFlag;
  assign full       = (r_count == (LSQ_WIDTH+1)'(LSQ_SIZE));
  assign w_enq      = addFlag & ~full & ~clearIn;

  // Head FSM and memory/result registers.
  head_state_e w_state;
  logic        w_memReg, w_outFlag;
  logic [2:0]  w_memOp;
  logic [31:0] w_memAddr, w_memData, w_outVal;
  tag_t        w_outDest;

  always_comb begin
    w_state   = r_state;
    w_memReg  = r_memReg;
    w_memOp   = r_memOp;
    w_memAddr = r_memAddr;
    w_memData = r_memData;
    w_outFlag = 1'b0;
    w_outVal  = r_outVal;
    w_outDest = r_outDest;
    case (r_state)
      ST_WAIT: begin
        if (w_canIssue) begin
          w_state   = ST_ISSUE;
          w_memReg  = 1'b1;
          w_memOp   = {w_isStore, w_h.op[1:0]};
          w_memAddr = w_h.vj + w_h.imm;
          w_memData = w_h.vk;
        end
      end
      ST_ISSUE: begin
        if (memOkFlag) begin
          w_state  = ST_WAIT;
          w_memReg = 1'b0;
          if (!w_isStore && !clearIn) begin
            w_outFlag = 1'b1;
            w_outVal  = extend(memDataIn, w_h.op);
            w_outDest = w_h.dest;
          end
        end else if (clearIn && !w_isStore) begin
          // Speculative load abandoned; a committed store keeps going.
          w_state  = ST_WAIT;
          w_memReg = 1'b0;
        end
      end
      default: w_state = ST_WAIT;
    endcase
  end

  // Queue contents: wakeup, commit, retire, then flush or enqueue.
  ent_t               w_q [LSQ_SIZE];
  idx_t               w_head, w_tail, w_lastCommit;
  logic [LSQ_WIDTH:0] w_cnt;
  logic               w_anyC;

  always_comb begin
    for (int i = 0; i < LSQ_SIZE; i++) begin
      w_q[i]        = r_q[i];
      w_q[i].qjBusy = w_qjBusy[i];
      w_q[i].vj     = w_vj[i];
      w_q[i].qkBusy = w_qkBusy[i];
      w_q[i].vk     = w_vk[i];
    end
    w_lastCommit = r_lastCommit;
    if (robFlag) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (r_q[i].busy && r_q[i].op[OP_STORE] && !r_q[i].committed &&
            (r_q[i].dest == robDest)) begin
          w_q[i].committed = 1'b1;
          w_lastCommit     = idx_t'(i);
        end
      end
    end
    w_head = r_head;
    if (w_done) begin
      w_q[r_head].busy = 1'b0;
      w_head           = r_head + idx_t'(1);
    end
    w_tail = r_tail;
    w_anyC = 1'b0;
    if (clearIn) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (!w_q[i].committed) w_q[i].busy = 1'b0;
        if (w_q[i].busy) w_anyC = 1'b1;
      end
      // Committed stores are contiguous from head, youngest at lastCommit.
      w_tail = w_anyC ? (w_lastCommit + idx_t'(1)) : w_head;
    end else if (w_enq) begin
      w_q[r_tail].busy      = 1'b1;
      w_q[r_tail].committed = 1'b0;
      w_q[r_tail].op        = addOp;
      w_q[r_tail].vj        = w_enqVj;
      w_q[r_tail].vk        = w_enqVk;
      w_q[r_tail].imm       = addImm;
      w_q[r_tail].qj        = addQj;
      w_q[r_tail].qk        = addQk;
      w_q[r_tail].qjBusy    = w_enqQjBusy;
      w_q[r_tail].qkBusy    = w_enqQkBusy;
      w_q[r_tail].dest      = addDest;
      w_tail                = r_tail + idx_t'(1);
    end
    w_cnt = '0;
    for (int i = 0; i < LSQ_SIZE; i++) w_cnt = w_cnt + (LSQ_WIDTH+1)'(w_q[i].busy);
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int i = 0; i < LSQ_SIZE; i++) r_q[i] <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_lastCommit <= '0;
      r_count      <= '0;
      r_state      <= ST_WAIT;
      r_memReg     <= 1'b0;
      r_memOp      <= '0;
      r_memAddr    <= '0;
      r_memData    <= '0;
      r_outFlag    <= 1'b0;
      r_outVal     <= '0;
      r_outDest    <= '0;
    end else if (readyIn) begin
      for (int i = 0; i < LSQ_SIZE; i++) r_q[i] <= w_q[i];
      r_head       <= w_head;
      r_tail       <= w_tail;
      r_lastCommit <= w_lastCommit;
      r_count      <= w_cnt;
      r_state      <= w_state;
      r_memReg     <= w_memReg;
      r_memOp      <= w_memOp;
      r_memAddr    <= w_memAddr;
      r_memData    <= w_memData;
      r_outFlag    <= w_outFlag;
      r_outVal     <= w_outVal;
      r_outDest    <= w_outDest;
    end
  end

  assign count      = r_count;
  assign outFlag    = r_outFlag;
  assign outVal     = r_outVal;
  assign outDest    = r_outDest;
  assign memOutFlag = r_memReg & ~memOkFlag;
  assign memOp      = r_memOp;
  assign memAddr    = r_memAddr;
  assign memDataOut = r_memData;

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;

  logic        clockIn = 0, resetIn, readyIn, clearIn, addFlag;
  logic [3:0]  addOp, addQj, addQk, addDest;
  logic [31:0] addVj, addVk, addImm;
  logic        addQjBusy, addQkBusy, full;
  logic [4:0]  count;
  logic [1:0]  cdbFlag;
  logic [63:0] cdbVal;
  logic [7:0]  cdbDest;
  logic        robFlag;
  logic [3:0]  robDest, robHead, outDest;
  logic        outFlag, memOutFlag, memOkFlag;
  logic [31:0] outVal, memAddr, memDataOut, memDataIn;
  logic [2:0]  memOp;

  localparam logic [3:0] OP_LW = 4'b0011, OP_LB = 4'b0000, OP_LBU = 4'b0100,
                         OP_LH = 4'b0001, OP_SW = 4'b1011;

  int total = 0, bad = 0;
  logic [31:0] sb_val[$];
  logic [3:0]  sb_dest[$];

  load_store_queue dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .addFlag(addFlag), .addOp(addOp), .addVj(addVj), .addVk(addVk),
    .addQj(addQj), .addQk(addQk), .addQjBusy(addQjBusy), .addQkBusy(addQkBusy),
    .addImm(addImm), .addDest(addDest), .full(full), .count(count),
    .cdbFlag(cdbFlag), .cdbVal(cdbVal), .cdbDest(cdbDest),
    .robFlag(robFlag), .robDest(robDest), .robHead(robHead),
    .outFlag(outFlag), .outVal(outVal), .outDest(outDest),
    .memOutFlag(memOutFlag), .memOp(memOp), .memAddr(memAddr),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .memOkFlag(memOkFlag));

  always #5 clockIn = ~clockIn;

  // Scoreboard: every load result pulse must match the oldest expectation.
  always @(negedge clockIn) begin
    if (outFlag === 1'b1) begin
      total++;
      if (sb_val.size() == 0) begin
        bad++;
        $display("FAIL outFlag_unexpected got val=%h dest=%0d", outVal, outDest);
      end else begin
        logic [31:0] ev; logic [3:0] ed;
        ev = sb_val.pop_front(); ed = sb_dest.pop_front();
        if (outVal !== ev || outDest !== ed) begin
          bad++;
          $display("FAIL load_result got val=%h dest=%0d want val=%h dest=%0d",
                   outVal, outDest, ev, ed);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clockIn);
    #1;
  endtask

  task automatic enq(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [31:0] imm, input logic [3:0] qj, input logic qjb,
                     input logic [3:0] dest);
    addFlag = 1; addOp = op; addVj = vj; addVk = vk; addImm = imm;
    addQj = qj; addQjBusy = qjb; addQk = 0; addQkBusy = 0; addDest = dest;
    step(1);
    addFlag = 0;
  endtask

  task automatic wait_mem();
    int n = 0;
    while (memOutFlag !== 1'b1 && n < 40) begin step(1); n++; end
    if (memOutFlag !== 1'b1) begin
      total++; bad++;
      $display("FAIL mem_request_timeout got memOutFlag=%b want 1", memOutFlag);
    end
  endtask

  task automatic respond(input logic [31:0] d);
    memDataIn = d; memOkFlag = 1;
    step(1);
    memOkFlag = 0;
  endtask

  task automatic push(input logic [31:0] v, input logic [3:0] d);
    sb_val.push_back(v); sb_dest.push_back(d);
  endtask

  task automatic test_reset();
    resetIn = 1; readyIn = 1; clearIn = 0; addFlag = 0; addOp = 0; addVj = 0; addVk = 0;
    addQj = 0; addQk = 0; addQjBusy = 0; addQkBusy = 0; addImm = 0; addDest = 0;
    cdbFlag = 0; cdbVal = 0; cdbDest = 0; robFlag = 0; robDest = 0; robHead = 0;
    memDataIn = 0; memOkFlag = 0;
    step(2);
    resetIn = 0;
    step(1);
    total++;
    if (count !== 0 || full !== 0 || outFlag !== 0 || memOutFlag !== 0 ||
        memAddr !== 0 || memOp !== 0 || memDataOut !== 0) begin
      bad++;
      $display("FAIL reset_state got count=%0d full=%b out=%b mem=%b addr=%h op=%0d want all 0",
               count, full, outFlag, memOutFlag, memAddr, memOp);
    end
  endtask

  task automatic test_lw();
    enq(OP_LW, 32'h100, 0, 32'h4, 0, 0, 4'd1);
    wait_mem();
    total++;
    if (memAddr !== 32'h104 || memOp !== 3'b011) begin
      bad++; $display("FAIL lw_issue got addr=%h op=%0d want addr=104 op=3", memAddr, memOp);
    end
    push(32'h80, 4'd1);
    respond(32'h80);
    total++;
    if (outFlag !== 1'b1) begin bad++; $display("FAIL lw_outflag_pulse got %b want 1", outFlag); end
    step(1);
    total++;
    if (outFlag !== 1'b0 || count !== 0) begin
      bad++; $display("FAIL lw_after got outFlag=%b count=%0d want 0 0", outFlag, count);
    end
  endtask

  task automatic test_extend();
    enq(OP_LBU, 32'h200, 0, 0, 0, 0, 4'd2);
    enq(OP_LB,  32'h201, 0, 0, 0, 0, 4'd3);
    enq(OP_LH,  32'h202, 0, 0, 0, 0, 4'd4);
    wait_mem(); push(32'h000000FF, 4'd2); respond(32'h000000FF);
    wait_mem(); push(32'hFFFFFFFF, 4'd3); respond(32'h000000FF);
    wait_mem();
    total++;
    if (memOp !== 3'b001) begin bad++; $display("FAIL lh_memop got %0d want 1", memOp); end
    push(32'hFFFF8001, 4'd4); respond(32'h12348001);
    step(2);
  endtask

  task automatic test_wakeup();
    enq(OP_LW, 0, 0, 32'h8, 4'd3, 1, 4'd4);
    step(3);
    total++;
    if (memOutFlag !== 1'b0) begin bad++; $display("FAIL wait_operand got mem=%b want 0", memOutFlag); end
    cdbFlag = 2'b10; cdbDest = {4'd3, 4'd0}; cdbVal = {32'h200, 32'h0};
    step(1);
    cdbFlag = 0;
    step(1);
    total++;
    if (memOutFlag !== 1'b1 || memAddr !== 32'h208) begin
      bad++; $display("FAIL cdb_wakeup got mem=%b addr=%h want 1 208", memOutFlag, memAddr);
    end
    push(32'h7, 4'd4); respond(32'h7);
    // Own load result forwards into a dependent load.
    enq(OP_LW, 32'h1000, 0, 0, 0, 0, 4'd5);
    enq(OP_LW, 0, 0, 32'h4, 4'd5, 1, 4'd6);
    wait_mem(); push(32'h300, 4'd5); respond(32'h300);
    wait_mem();
    total++;
    if (memAddr !== 32'h304) begin bad++; $display("FAIL self_forward got addr=%h want 304", memAddr); end
    push(32'h11, 4'd6); respond(32'h11);
    step(2);
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) enq(OP_LW, 32'(i * 4), 0, 0, 0, 0, 4'(i));
    total++;
    if (full !== 1'b1 || count !== 16) begin
      bad++; $display("FAIL full got full=%b count=%0d want 1 16", full, count);
    end
    // Enqueue while full is refused; the retire still happens.
    addFlag = 1; addOp = OP_LW; addVj = 32'h3C0; addQjBusy = 0; addImm = 0; addDest = 4'd14;
    push(32'h1000, 4'd0); memDataIn = 32'h1000; memOkFlag = 1;
    step(1);
    addFlag = 0; memOkFlag = 0;
    total++;
    if (count !== 15 || full !== 1'b0) begin
      bad++; $display("FAIL full_reject got count=%0d full=%b want 15 0", count, full);
    end
    wait_mem();
    addFlag = 1; push(32'h1001, 4'd1); memDataIn = 32'h1001; memOkFlag = 1;
    step(1);
    addFlag = 0; memOkFlag = 0;
    total++;
    if (count !== 15) begin bad++; $display("FAIL enq_retire_same got count=%0d want 15", count); end
    for (int i = 2; i < 16; i++) begin
      wait_mem();
      total++;
      if (memAddr !== 32'(i * 4)) begin
        bad++; $display("FAIL drain_addr%0d got %h want %h", i, memAddr, i * 4);
      end
      push(32'h1000 + 32'(i), 4'(i)); respond(32'h1000 + 32'(i));
    end
    wait_mem();
    total++;
    if (memAddr !== 32'h3C0) begin bad++; $display("FAIL wrap_entry got addr=%h want 3c0", memAddr); end
    push(32'hABC, 4'd14); respond(32'hABC);
    step(1);
    total++;
    if (count !== 0) begin bad++; $display("FAIL drained got count=%0d want 0", count); end
  endtask

  task automatic test_clear();
    enq(OP_SW, 32'h40, 32'hDEAD, 0, 0, 0, 4'd7);
    enq(OP_LW, 32'h80, 0, 0, 0, 0, 4'd8);
    step(2);
    total++;
    if (memOutFlag !== 1'b0) begin bad++; $display("FAIL store_precommit got mem=%b want 0", memOutFlag); end
    robFlag = 1; robDest = 4'd7;
    step(1);
    robFlag = 0;
    wait_mem();
    total++;
    if (memOp !== 3'b111 || memAddr !== 32'h40 || memDataOut !== 32'hDEAD) begin
      bad++; $display("FAIL store_issue got op=%0d addr=%h data=%h want 7 40 dead", memOp, memAddr, memDataOut);
    end
    clearIn = 1; step(1); clearIn = 0;
    total++;
    if (count !== 1 || memOutFlag !== 1'b1) begin
      bad++; $display("FAIL clear_keep_store got count=%0d mem=%b want 1 1", count, memOutFlag);
    end
    enq(OP_LW, 32'h500, 0, 0, 0, 0, 4'd9);
    total++;
    if (count !== 2) begin bad++; $display("FAIL clear_tail got count=%0d want 2", count); end
    respond(32'h0);
    wait_mem();
    total++;
    if (memAddr !== 32'h500) begin bad++; $display("FAIL after_clear got addr=%h want 500", memAddr); end
    push(32'h55, 4'd9); respond(32'h55);
    // In-flight load is dropped by a flush.
    enq(OP_LW, 32'h600, 0, 0, 0, 0, 4'd10);
    wait_mem();
    clearIn = 1; step(1); clearIn = 0;
    total++;
    if (memOutFlag !== 1'b0 || count !== 0) begin
      bad++; $display("FAIL drop_load got mem=%b count=%0d want 0 0", memOutFlag, count);
    end
    step(3);
    enq(OP_LW, 32'h700, 0, 0, 0, 0, 4'd11);
    wait_mem();
    total++;
    if (memAddr !== 32'h700) begin bad++; $display("FAIL post_drop got addr=%h want 700", memAddr); end
    push(32'h77, 4'd11); respond(32'h77);
    step(2);
  endtask

  task automatic test_stall();
    enq(OP_LW, 32'h900, 0, 0, 0, 0, 4'd12);
    wait_mem();
    readyIn = 0;
    addFlag = 1; addDest = 4'd13;
    step(2);
    addFlag = 0;
    total++;
    if (memOutFlag !== 1'b1 || count !== 1) begin
      bad++; $display("FAIL stall_hold got mem=%b count=%0d want 1 1", memOutFlag, count);
    end
    readyIn = 1;
    push(32'h99, 4'd12); respond(32'h99);
    step(2);
  endtask

  task automatic test_mmio();
    robHead = 4'd2;
    enq(OP_LW, 32'h30000, 0, 0, 0, 0, 4'd5);
    step(4);
`ifdef LSQ_MMIO_GUARD_EN
    total++;
    if (memOutFlag !== 1'b0) begin bad++; $display("FAIL mmio_guard got mem=%b want 0", memOutFlag); end
    robHead = 4'd5;
    step(2);
`endif
    total++;
    if (memOutFlag !== 1'b1 || memAddr !== 32'h30000) begin
      bad++; $display("FAIL mmio_issue got mem=%b addr=%h want 1 30000", memOutFlag, memAddr);
    end
    push(32'h5A, 4'd5); respond(32'h5A);
    robHead = 0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_wakeup();
    test_full();
    test_clear();
    test_stall();
    test_mmio();
    step(2);
    total++;
    if (sb_val.size() != 0) begin
      bad++; $display("FAIL missing_results got pending=%0d want 0", sb_val.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
